// File: rtl/frame_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frame_pkg
//  Description : Shared definitions for the frame TX/RX pair: the 3-bit line
//                state encoding reported on o_state, preamble/SFD byte values,
//                CRC-32 constants and the byte-wide reflected CRC-32 update.
//  Revision    : 1.0 - initial release
// ============================================================================
package frame_pkg;

    // 3-bit line-state code, identical on the TX and RX sides so one decoder
    // serves the MAC table and monitor logic.
    typedef logic [2:0] frame_state_t;

    localparam frame_state_t c_ST_IDLE     = 3'd0;  // idle, IFG, drain
    localparam frame_state_t c_ST_PREAMBLE = 3'd1;
    localparam frame_state_t c_ST_SFD      = 3'd2;
    localparam frame_state_t c_ST_DA       = 3'd3;
    localparam frame_state_t c_ST_SA       = 3'd4;
    localparam frame_state_t c_ST_LEN      = 3'd5;
    localparam frame_state_t c_ST_DATA     = 3'd6;
    localparam frame_state_t c_ST_FCS      = 3'd7;

    localparam logic [7:0]  c_PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  c_SFD_BYTE      = 8'hD5;

    localparam logic [31:0] c_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] c_CRC_POLY    = 32'hEDB8_8320;  // reflected 0x04C11DB7
    localparam logic [31:0] c_CRC_RESIDUE = 32'hC704_DD7B;

    // One byte of CRC-32, data consumed LSB first as it goes on the wire.
    function automatic logic [31:0] eth_crc32_8d(input logic [31:0] crc,
                                                  input logic [7:0]  data);
        logic [31:0] r;
        r = crc;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ data[i]) begin
                r = (r >> 1) ^ c_CRC_POLY;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_tx_crc32.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tx_crc32
//  Description : Running CRC-32 register for the transmitter. Reloads to
//                all-ones on i_init, folds in one byte per cycle on i_en.
//  Ports       : clk, rst (sync, active high), i_init, i_en, i_data[7:0],
//                o_crc[31:0] (un-inverted running remainder)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_crc32
    import frame_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] r_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_crc <= c_CRC_INIT;
        end else if (i_init) begin
            r_crc <= c_CRC_INIT;
        end else if (i_en) begin
            r_crc <= eth_crc32_8d(r_crc, i_data);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_transmitter
//  Description : 8-bit MII/GMII-style Ethernet frame transmitter. Accepts a
//                DA/SA/LEN/DATA byte stream over valid/ready and puts
//                preamble, SFD, stream bytes, optional pad and FCS on the
//                line, then holds the inter-frame gap. Underrun, runt and
//                oversize frames are cut with a single otx_er cycle.
//  Config      : FRAME_TX_PAD_EN - when defined, short DATA fields are padded
//                with 0x00 up to MIN_DATA bytes before the FCS.
//  Ports       : iclk, irst (sync, active high)
//                i_data[7:0], i_valid, i_last, o_ready  - stream side
//                otx_data[7:0], otx_en, otx_er         - line side (registered)
//                o_state[2:0], o_busy                  - status (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_transmitter
    import frame_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12,
    parameter int MIN_DATA     = 46,
    parameter int MAX_DATA     = 1500
) (
    input  logic       iclk,
    input  logic       irst,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic [7:0] otx_data,
    output logic       otx_en,
    output logic       otx_er,
    output logic [2:0] o_state,
    output logic       o_busy
);

`ifdef FRAME_TX_PAD_EN
    localparam bit c_PAD_EN = 1'b1;
`else
    localparam bit c_PAD_EN = 1'b0;
`endif

    // Internal sequencer states; wider than o_state because IFG, DRAIN and
    // PAD share an external code with IDLE/DATA.
    localparam logic [3:0] c_S_IDLE  = 4'd0;
    localparam logic [3:0] c_S_PRE   = 4'd1;
    localparam logic [3:0] c_S_SFD   = 4'd2;
    localparam logic [3:0] c_S_DA    = 4'd3;
    localparam logic [3:0] c_S_SA    = 4'd4;
    localparam logic [3:0] c_S_LEN   = 4'd5;
    localparam logic [3:0] c_S_DATA  = 4'd6;
    localparam logic [3:0] c_S_FCS   = 4'd7;
    localparam logic [3:0] c_S_IFG   = 4'd8;
    localparam logic [3:0] c_S_DRAIN = 4'd9;
    localparam logic [3:0] c_S_PAD   = 4'd10;

    // Field counter covers preamble, IFG, DA/SA (6) and FCS (4) lengths.
    localparam int c_FCNT_MAX = (PREAMBLE_LEN > IFG_CYCLES) ? PREAMBLE_LEN : IFG_CYCLES;
    localparam int c_FCNT_TOP = (c_FCNT_MAX > 6) ? c_FCNT_MAX : 6;
    localparam int c_FCNT_W   = $clog2(c_FCNT_TOP);

    localparam logic [c_FCNT_W-1:0] c_FCNT_ONE = c_FCNT_W'(1);
    localparam logic [c_FCNT_W-1:0] c_PRE_LAST = c_FCNT_W'(PREAMBLE_LEN - 1);
    localparam logic [c_FCNT_W-1:0] c_IFG_LAST = c_FCNT_W'(IFG_CYCLES - 1);
    localparam logic [c_FCNT_W-1:0] c_FCS_LAST = c_FCNT_W'(3);
    localparam logic [c_FCNT_W-1:0] c_ADR_LAST = c_FCNT_W'(5);
    localparam logic [c_FCNT_W-1:0] c_LEN_LAST = c_FCNT_W'(1);

    localparam logic [10:0] c_MAX_CNT = 11'(MAX_DATA);
    localparam logic [10:0] c_MIN_CNT = 11'(MIN_DATA);
    localparam logic [10:0] c_CNT_SAT = 11'h7FF;

    logic [3:0]          r_st;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [10:0]         r_cnt;

    logic [31:0]         w_crc;
    logic                w_crc_init;
    logic                w_crc_en;
    logic [7:0]          w_crc_data;
    logic                w_hdr_st;
    logic [10:0]         w_cnt_inc;
    logic [7:0]          w_fcs_byte;
    frame_state_t        w_field_state;
    logic [c_FCNT_W-1:0] w_field_last;
    logic [3:0]          w_field_next;

    assign w_hdr_st = (r_st == c_S_DA) || (r_st == c_S_SA) || (r_st == c_S_LEN);

    assign o_ready  = w_hdr_st || (r_st == c_S_DATA) || (r_st == c_S_DRAIN);

    assign w_cnt_inc = (r_cnt == c_CNT_SAT) ? r_cnt : (r_cnt + 11'd1);

    // CRC restarts while SFD goes out; pad bytes are covered like data.
    assign w_crc_init = (r_st == c_S_SFD);
    assign w_crc_en   = (i_valid && (w_hdr_st || (r_st == c_S_DATA))) || (r_st == c_S_PAD);
    assign w_crc_data = (r_st == c_S_PAD) ? 8'h00 : i_data;

    frame_tx_crc32 u_crc (
        .clk    (iclk),
        .rst    (irst),
        .i_init (w_crc_init),
        .i_en   (w_crc_en),
        .i_data (w_crc_data),
        .o_crc  (w_crc)
    );

    // FCS is the complemented remainder, least significant byte first.
    always_comb begin
        w_fcs_byte = 8'h00;
        case (r_fcnt[1:0])
            2'd0:    w_fcs_byte = ~w_crc[7:0];
            2'd1:    w_fcs_byte = ~w_crc[15:8];
            2'd2:    w_fcs_byte = ~w_crc[23:16];
            default: w_fcs_byte = ~w_crc[31:24];
        endcase
    end

    always_comb begin
        w_field_state = c_ST_DA;
        w_field_last  = c_ADR_LAST;
        w_field_next  = c_S_SA;
        case (r_st)
            c_S_SA: begin
                w_field_state = c_ST_SA;
                w_field_last  = c_ADR_LAST;
                w_field_next  = c_S_LEN;
            end
            c_S_LEN: begin
                w_field_state = c_ST_LEN;
                w_field_last  = c_LEN_LAST;
                w_field_next  = c_S_DATA;
            end
            default: begin
                w_field_state = c_ST_DA;
                w_field_last  = c_ADR_LAST;
                w_field_next  = c_S_SA;
            end
        endcase
    end

    // Every line/status output is registered: each edge emits what the
    // current state produces, so the line trails the sequencer by one cycle.
    always_ff @(posedge iclk) begin
        if (irst) begin
            r_st     <= c_S_IDLE;
            r_fcnt   <= '0;
            r_cnt    <= '0;
            otx_data <= 8'h00;
            otx_en   <= 1'b0;
            otx_er   <= 1'b0;
            o_state  <= c_ST_IDLE;
            o_busy   <= 1'b0;
        end else begin
            otx_data <= 8'h00;
            otx_en   <= 1'b0;
            otx_er   <= 1'b0;
            o_state  <= c_ST_IDLE;
            o_busy   <= 1'b1;

            case (r_st)
                c_S_IDLE: begin
                    o_busy <= i_valid;
                    if (i_valid) begin
                        r_fcnt <= '0;
                        r_st   <= c_S_PRE;
                    end
                end

                c_S_PRE: begin
                    otx_en   <= 1'b1;
                    otx_data <= c_PREAMBLE_BYTE;
                    o_state  <= c_ST_PREAMBLE;
                    if (r_fcnt == c_PRE_LAST) begin
                        r_fcnt <= '0;
                        r_st   <= c_S_SFD;
                    end else begin
                        r_fcnt <= r_fcnt + c_FCNT_ONE;
                    end
                end

                c_S_SFD: begin
                    otx_en   <= 1'b1;
                    otx_data <= c_SFD_BYTE;
                    o_state  <= c_ST_SFD;
                    r_cnt    <= '0;
                    r_st     <= c_S_DA;
                end

                c_S_DA, c_S_SA, c_S_LEN: begin
                    if (!i_valid) begin
                        // Underrun: error cycle, then swallow the rest.
                        otx_en <= 1'b1;
                        otx_er <= 1'b1;
                        r_st   <= c_S_DRAIN;
                    end else if (i_last) begin
                        // Runt: the stream has already ended, nothing to drain.
                        otx_en <= 1'b1;
                        otx_er <= 1'b1;
                        r_fcnt <= '0;
                        r_st   <= c_S_IFG;
                    end else begin
                        otx_en   <= 1'b1;
                        otx_data <= i_data;
                        o_state  <= w_field_state;
                        if (r_fcnt == w_field_last) begin
                            r_fcnt <= '0;
                            r_st   <= w_field_next;
                        end else begin
                            r_fcnt <= r_fcnt + c_FCNT_ONE;
                        end
                    end
                end

                c_S_DATA: begin
                    if (r_cnt == c_MAX_CNT) begin
                        // Oversize: this slot becomes the error cycle; if the
                        // byte taken here was the last one, skip the drain.
                        otx_en <= 1'b1;
                        otx_er <= 1'b1;
                        r_fcnt <= '0;
                        r_st   <= (i_valid && i_last) ? c_S_IFG : c_S_DRAIN;
                    end else if (!i_valid) begin
                        otx_en <= 1'b1;
                        otx_er <= 1'b1;
                        r_st   <= c_S_DRAIN;
                    end else begin
                        otx_en   <= 1'b1;
                        otx_data <= i_data;
                        o_state  <= c_ST_DATA;
                        r_cnt    <= w_cnt_inc;
                        if (i_last) begin
                            r_fcnt <= '0;
                            r_st   <= (c_PAD_EN && (w_cnt_inc < c_MIN_CNT)) ? c_S_PAD : c_S_FCS;
                        end
                    end
                end

                c_S_PAD: begin
                    otx_en  <= 1'b1;
                    o_state <= c_ST_DATA;
                    r_cnt   <= w_cnt_inc;
                    if (w_cnt_inc >= c_MIN_CNT) begin
                        r_st <= c_S_FCS;
                    end
                end

                c_S_FCS: begin
                    otx_en   <= 1'b1;
                    otx_data <= w_fcs_byte;
                    o_state  <= c_ST_FCS;
                    if (r_fcnt == c_FCS_LAST) begin
                        r_fcnt <= '0;
                        r_st   <= c_S_IFG;
                    end else begin
                        r_fcnt <= r_fcnt + c_FCNT_ONE;
                    end
                end

                c_S_IFG: begin
                    // A waiting frame starts straight from the last gap
                    // cycle so back-to-back frames see exactly IFG_CYCLES.
                    if (r_fcnt == c_IFG_LAST) begin
                        r_fcnt <= '0;
                        r_st   <= i_valid ? c_S_PRE : c_S_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt + c_FCNT_ONE;
                    end
                end

                c_S_DRAIN: begin
                    if (i_valid && i_last) begin
                        r_fcnt <= '0;
                        r_st   <= c_S_IFG;
                    end
                end

                default: begin
                    r_st <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_transmitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_frame_transmitter
//  Description : Directed bench for frame_transmitter: clean, short, runt,
//                underrun, boundary-length and oversize frames plus reset
//                during DATA. Expected pad depends on FRAME_TX_PAD_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_transmitter;

`ifdef FRAME_TX_PAD_EN
    localparam bit c_PAD_EN = 1'b1;
`else
    localparam bit c_PAD_EN = 1'b0;
`endif

    localparam int c_MIN_DATA = 46;

    logic       iclk = 1'b0;
    logic       irst;
    logic [7:0] i_data;
    logic       i_valid;
    logic       i_last;
    logic       o_ready;
    logic [7:0] otx_data;
    logic       otx_en;
    logic       otx_er;
    logic [2:0] o_state;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    frame_transmitter u_dut (
        .iclk     (iclk),
        .irst     (irst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .o_ready  (o_ready),
        .otx_data (otx_data),
        .otx_en   (otx_en),
        .otx_er   (otx_er),
        .o_state  (o_state),
        .o_busy   (o_busy)
    );

    always #5 iclk = ~iclk;

    // n: stream bytes incl. 14-byte header, i_last on the final one.
    // drop_at: stream index where i_valid is withheld once (-1 = never).
    typedef struct {
        int n;
        int drop_at;
        int exp_en;
        int exp_er;
        int exp_gap;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int vid, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, vid, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [2:0] byte_state(input int i);
        if (i < 6)  return 3'd3;
        if (i < 12) return 3'd4;
        if (i < 14) return 3'd5;
        return 3'd6;
    endfunction

    task automatic run_vec(input vec_t v, input int vid);
        logic [7:0]  bytes[$];
        logic [7:0]  exp_d[$];
        logic [2:0]  exp_s[$];
        logic        exp_e[$];
        logic [7:0]  cap_d[$];
        logic [2:0]  cap_s[$];
        logic        cap_e[$];
        logic [31:0] crc;
        int idx, cyc, lead, gap, gap_bad, n_er, pad, k, mism;
        bit seen_busy, seen_en, dropped, done;

        for (int i = 0; i < v.n; i++) bytes.push_back(8'((i * 13 + vid * 29 + 5) & 255));

        for (int i = 0; i < 7; i++) begin
            exp_d.push_back(8'h55); exp_s.push_back(3'd1); exp_e.push_back(1'b0);
        end
        exp_d.push_back(8'hD5); exp_s.push_back(3'd2); exp_e.push_back(1'b0);
        if (v.exp_er != 0) begin
            k = v.exp_en - 9;
            for (int i = 0; i < k; i++) begin
                exp_d.push_back(bytes[i]); exp_s.push_back(byte_state(i)); exp_e.push_back(1'b0);
            end
            exp_d.push_back(8'h00); exp_s.push_back(3'd0); exp_e.push_back(1'b1);
        end else begin
            crc = 32'hFFFFFFFF;
            pad = (c_PAD_EN && (v.n - 14 < c_MIN_DATA)) ? (c_MIN_DATA - (v.n - 14)) : 0;
            for (int i = 0; i < v.n; i++) begin
                exp_d.push_back(bytes[i]); exp_s.push_back(byte_state(i)); exp_e.push_back(1'b0);
                crc = crc_step(crc, bytes[i]);
            end
            for (int i = 0; i < pad; i++) begin
                exp_d.push_back(8'h00); exp_s.push_back(3'd6); exp_e.push_back(1'b0);
                crc = crc_step(crc, 8'h00);
            end
            crc = ~crc;
            for (int i = 0; i < 4; i++) begin
                exp_d.push_back(crc[7:0]); exp_s.push_back(3'd7); exp_e.push_back(1'b0);
                crc = crc >> 8;
            end
        end

        idx = 0; cyc = 0; lead = 0; gap = 0; gap_bad = 0; n_er = 0;
        seen_busy = 0; seen_en = 0; dropped = 0; done = 0;
        while (!done && cyc < v.n + 200) begin
            @(negedge iclk);
            cyc++;
            if (otx_er) n_er++;
            if (otx_en) begin
                seen_en = 1;
                cap_d.push_back(otx_data); cap_s.push_back(o_state); cap_e.push_back(otx_er);
            end else if (o_busy) begin
                if (!seen_en) lead++;
                else begin
                    gap++;
                    if (o_state != 3'd0) gap_bad++;
                end
            end
            if (o_busy) seen_busy = 1;
            else if (seen_busy) done = 1;

            if (done || idx >= v.n) begin
                i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00;
            end else if (idx == v.drop_at && !dropped && o_ready) begin
                dropped = 1; i_valid = 1'b0; i_last = 1'b0;
            end else begin
                i_valid = 1'b1; i_data = bytes[idx]; i_last = (idx == v.n - 1);
            end
            if (i_valid && o_ready) idx++;
        end

        mism = 0;
        if (cap_d.size() != exp_d.size()) mism++;
        for (int i = 0; i < cap_d.size() && i < exp_d.size(); i++) begin
            if (cap_d[i] !== exp_d[i] || cap_s[i] !== exp_s[i] || cap_e[i] !== exp_e[i]) mism++;
        end

        check("frame_done",  vid, int'(done), 1);
        check("lead_cycles", vid, lead, 1);
        check("en_cycles",   vid, cap_d.size(), v.exp_en);
        check("er_cycles",   vid, n_er, v.exp_er);
        check("line_seq",    vid, mism, 0);
        check("gap_cycles",  vid, gap, v.exp_gap);
        check("gap_state",   vid, gap_bad, 0);
    endtask

    initial begin
        int idx;
        int en_seen;

        //          n     drop  en                      er gap
        vecs[0]  = '{60,   -1,  72,                     0, 12};  // 46 data
        vecs[1]  = '{24,   -1,  c_PAD_EN ? 72 : 36,     0, 12};  // 10 data
        vecs[2]  = '{20,   -1,  c_PAD_EN ? 72 : 32,     0, 12};  // 6 data
        vecs[3]  = '{30,    8,  17,                     1, 34};  // underrun 3rd SA
        vecs[4]  = '{20,    0,   9,                     1, 32};  // underrun 1st DA
        vecs[5]  = '{40,   20,  29,                     1, 32};  // underrun in DATA
        vecs[6]  = '{10,   -1,  18,                     1, 12};  // runt in SA
        vecs[7]  = '{14,   -1,  22,                     1, 12};  // runt on last LEN
        vecs[8]  = '{1514, -1,  1526,                   0, 12};  // exactly MAX_DATA
        vecs[9]  = '{1516, -1,  1523,                   1, 13};  // oversize
        vecs[10] = '{15,   -1,  c_PAD_EN ? 72 : 27,     0, 12};  // 1 data

        irst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00;
        repeat (3) @(negedge iclk);
        check("reset_outputs", -1,
              int'({otx_en, otx_er, otx_data, o_state, o_busy, o_ready}), 0);
        irst = 1'b0;

        for (int v = 0; v < 11; v++) run_vec(vecs[v], v);

        // Reset while DATA is on the line, then a clean frame.
        idx = 0; en_seen = 0;
        for (int c = 0; c < 200 && en_seen < 30; c++) begin
            @(negedge iclk);
            if (otx_en) en_seen++;
            i_valid = 1'b1; i_data = 8'((idx * 3 + 1) & 255); i_last = 1'b0;
            if (o_ready) idx++;
        end
        check("reach_data", 90, en_seen, 30);
        check("in_data_state", 90, int'(o_state), 6);
        irst = 1'b1; i_valid = 1'b0;
        @(negedge iclk);
        check("midframe_reset", 91,
              int'({otx_en, otx_er, otx_data, o_state, o_busy, o_ready}), 0);
        irst = 1'b0;
        @(negedge iclk);
        check("post_reset_idle", 92, int'({otx_en, o_busy, o_ready}), 0);
        run_vec(vecs[0], 93);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
